// File: rtl/data_uart_tx_if.sv
// data_uart_tx_if: byte write port between the readout data FIFO and the UART
// framer. The FIFO side drives the write strobe and data; the framer returns
// its full flag so the writer can see refused writes.
interface data_uart_tx_if;
    logic       IN_WR;
    logic [7:0] IN_DATA;
    logic       IN_FULL;

    // Upstream writer
    modport master (
        output IN_WR,
        output IN_DATA,
        input  IN_FULL
    );

    // UART framer
    modport slave (
        input  IN_WR,
        input  IN_DATA,
        output IN_FULL
    );
endinterface

// File: rtl/data_uart_tx.sv
// data_uart_tx: buffers bytes from the readout FIFO and sends them as framed
// packets (0xA5, LEN, payload, optional checksum) over an 8N1 UART line.
// Build option: define DATA_UART_TX_CHECKSUM_EN to append the mod-256 checksum
// byte (sum of LEN and payload). Without it the frame ends after the payload.
module data_uart_tx #(
    parameter int unsigned CLK_DIV      = 434,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned FLUSH_CYCLES = 50000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    data_uart_tx_if.slave        bus,
    output logic                 UART_TX,
    output logic                 BUSY,
    output logic [15:0]          FRAME_CNT,
    output logic [7:0]           DROP_CNT
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [23:0] FLUSH_MAX = 24'(FLUSH_CYCLES);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
`ifdef DATA_UART_TX_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd4;
`endif

    // ---------------------------------------------------------------
    // Byte buffer
    // ---------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_rd_data;

    logic w_full;
    logic w_push;
    logic w_pop;

    // ---------------------------------------------------------------
    // Framer / serialiser state
    // ---------------------------------------------------------------
    logic [2:0]  r_state;
    logic [15:0] r_div;
    logic [3:0]  r_bit;
    logic [7:0]  r_byte;
    logic [7:0]  r_len;
    logic [7:0]  r_sent;
    logic        r_tx;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_drop_cnt;
    logic [23:0] r_timer;
`ifdef DATA_UART_TX_CHECKSUM_EN
    logic [7:0]  r_csum;
    logic [7:0]  w_csum_next;
`endif

    logic       w_start;
    logic [7:0] w_len_start;
    logic       w_bit_end;
    logic       w_last;
    logic [7:0] w_cur_byte;
    logic       w_count_ge_max;

    // Full is a pure decode of the count register so it never depends on IN_WR.
    assign w_full = (r_count == COUNT_FULL);
    assign w_push = bus.IN_WR && !w_full;

    // The payload byte is fetched in the first cycle of each DATA slot, while
    // the start bit is already on the line; it is needed only at the end of
    // that bit, which leaves room for the registered RAM read.
    assign w_pop = (r_state == ST_DATA) && (r_div == 16'd0) && (r_bit == 4'd0);

    // Frame start looks at the count before this cycle's push.
    assign w_count_ge_max = (32'(r_count) >= MAX_LEN);
    assign w_start = (r_state == ST_IDLE) &&
                     (w_count_ge_max || ((r_count != '0) && (r_timer == FLUSH_MAX)));
    assign w_len_start = w_count_ge_max ? 8'(MAX_LEN) : 8'(r_count);

    assign w_bit_end  = (r_div == DIV_LAST);
    assign w_last     = ((r_sent + 8'd1) == r_len);
    // During DATA the shifted byte comes straight from the RAM read register.
    assign w_cur_byte = (r_state == ST_DATA) ? r_rd_data : r_byte;

`ifdef DATA_UART_TX_CHECKSUM_EN
    assign w_csum_next = r_csum + r_rd_data;
`endif

    assign bus.IN_FULL = w_full;
    assign UART_TX     = r_tx;
    assign BUSY        = (r_state != ST_IDLE);
    assign FRAME_CNT   = r_frame_cnt;
    assign DROP_CNT    = r_drop_cnt;

    // RAM storage with registered read; contents need no reset because the
    // pointers and count define which entries are valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.IN_DATA;
        end
        if (w_pop) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // Buffer pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Refused writes are counted, saturating so the count never wraps to a small value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_drop_cnt <= '0;
        end else if (bus.IN_WR && w_full && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // Idle timer that flushes a short frame once the writer goes quiet.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_timer <= '0;
        end else if (w_push || w_start) begin
            r_timer <= '0;
        end else if ((r_state == ST_IDLE) && (r_count != '0) && (r_timer != FLUSH_MAX)) begin
            r_timer <= r_timer + 24'd1;
        end
    end

    // Frame sequencer and bit serialiser: each byte slot is 10 bits of
    // CLK_DIV cycles, and the next slot's start bit is driven on the same
    // edge that ends the previous stop bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
            r_len       <= '0;
            r_sent      <= '0;
            r_tx        <= 1'b1;
            r_frame_cnt <= '0;
`ifdef DATA_UART_TX_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_SYNC;
                        r_byte  <= SYNC_BYTE;
                        r_len   <= w_len_start;
                        r_sent  <= '0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
`ifdef DATA_UART_TX_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                default: begin
                    if (!w_bit_end) begin
                        r_div <= r_div + 16'd1;
                    end else if (r_bit != 4'd9) begin
                        // Next bit: data LSB first, then the stop bit.
                        r_div <= '0;
                        r_bit <= r_bit + 4'd1;
                        r_tx  <= (r_bit == 4'd8) ? 1'b1 : w_cur_byte[r_bit[2:0]];
                    end else begin
                        // End of a byte slot: choose what the next slot carries.
                        r_div <= '0;
                        r_bit <= '0;
                        case (r_state)
                            ST_SYNC: begin
                                r_state <= ST_LEN;
                                r_byte  <= r_len;
                                r_tx    <= 1'b0;
                            end
                            ST_LEN: begin
                                r_state <= ST_DATA;
                                r_tx    <= 1'b0;
`ifdef DATA_UART_TX_CHECKSUM_EN
                                r_csum  <= r_csum + r_len;
`endif
                            end
                            ST_DATA: begin
                                r_sent <= r_sent + 8'd1;
`ifdef DATA_UART_TX_CHECKSUM_EN
                                r_csum <= w_csum_next;
                                r_tx   <= 1'b0;
                                if (w_last) begin
                                    r_state <= ST_CSUM;
                                    r_byte  <= w_csum_next;
                                end
`else
                                if (w_last) begin
                                    r_state     <= ST_IDLE;
                                    r_tx        <= 1'b1;
                                    r_frame_cnt <= r_frame_cnt + 16'd1;
                                end else begin
                                    r_tx <= 1'b0;
                                end
`endif
                            end
`ifdef DATA_UART_TX_CHECKSUM_EN
                            ST_CSUM: begin
                                r_state     <= ST_IDLE;
                                r_tx        <= 1'b1;
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end
`endif
                            default: begin
                                r_state <= ST_IDLE;
                                r_tx    <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_uart_tx.sv
// tb_data_uart_tx: directed bench for data_uart_tx with CLK_DIV=4, DEPTH=8,
// MAX_LEN=4, FLUSH_CYCLES=100. Expected frames follow the build option
// DATA_UART_TX_CHECKSUM_EN (checksum byte present only when it is defined).
module tb_data_uart_tx;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_tx;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;

    data_uart_tx_if bus ();

    data_uart_tx #(
        .CLK_DIV      (4),
        .DEPTH        (8),
        .MAX_LEN      (4),
        .FLUSH_CYCLES (100)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .bus       (bus),
        .UART_TX   (uart_tx),
        .BUSY      (busy),
        .FRAME_CNT (frame_cnt),
        .DROP_CNT  (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Line receiver: samples each bit in its middle and queues decoded bytes.
    logic [7:0] mon_b;
    int         framing_err = 0;
    logic [7:0] rx_q [$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx == 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    mon_b[i] = uart_tx;
                end
                repeat (DIV) @(negedge clk);
                if (uart_tx !== 1'b1) framing_err++;
                rx_q.push_back(mon_b);
                @(negedge clk);
            end
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int               n;
        logic [0:3][7:0]  data;
        logic [0:6][7:0]  line;
        int               lat;
        int               dur_cs;
        int               dur_nocs;
    } vec_t;

    vec_t vecs [5];

    logic [7:0] exp_fill [$];
    logic [7:0] pay_q [$];

    int  frames_exp;
    int  last_wr, t0, nb, first_wr, pop_neg, lows, n_drop_model, idx, plen;
    bit  got;

    initial begin
        vecs[0] = '{4, '{8'h01, 8'h02, 8'h03, 8'h04}, '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E}, 1,   280, 240};
        vecs[1] = '{4, '{8'h10, 8'h20, 8'h30, 8'h40}, '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA4}, 1,   280, 240};
        vecs[2] = '{1, '{8'h55, 8'h00, 8'h00, 8'h00}, '{8'hA5, 8'h01, 8'h55, 8'h56, 8'h00, 8'h00, 8'h00}, 101, 160, 120};
        vecs[3] = '{2, '{8'hFF, 8'h80, 8'h00, 8'h00}, '{8'hA5, 8'h02, 8'hFF, 8'h80, 8'h81, 8'h00, 8'h00}, 101, 200, 160};
        vecs[4] = '{3, '{8'h00, 8'hFF, 8'h01, 8'h00}, '{8'hA5, 8'h03, 8'h00, 8'hFF, 8'h01, 8'h03, 8'h00}, 101, 240, 200};
`ifdef DATA_UART_TX_CHECKSUM_EN
        exp_fill = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E,
                     8'hA5, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1E};
`else
        exp_fill = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04,
                     8'hA5, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`endif

        bus.IN_WR   = 1'b0;
        bus.IN_DATA = 8'h00;
        frames_exp  = 0;

        // Reset values, observed while reset is held
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_in_full", bus.IN_FULL, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            rx_q.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                @(negedge clk);
                bus.IN_WR   = 1'b1;
                bus.IN_DATA = vecs[v].data[i];
            end
            @(negedge clk);
            bus.IN_WR = 1'b0;
            last_wr   = cyc;

            got = 0;
            for (int k = 0; k < 400 && !got; k++) begin
                @(negedge clk);
                if (uart_tx == 1'b0) got = 1;
            end
            check($sformatf("v%0d_start_seen", v), int'(got), 1);
            t0 = cyc;
            check($sformatf("v%0d_start_latency", v), t0 - last_wr, vecs[v].lat);
            check($sformatf("v%0d_busy_at_start", v), busy, 1);

            got = 0;
            for (int k = 0; k < 1000 && !got; k++) begin
                @(negedge clk);
                if (busy == 1'b0) got = 1;
            end
            check($sformatf("v%0d_busy_fall_seen", v), int'(got), 1);
`ifdef DATA_UART_TX_CHECKSUM_EN
            check($sformatf("v%0d_frame_cycles", v), cyc - t0, vecs[v].dur_cs);
            nb = vecs[v].n + 3;
`else
            check($sformatf("v%0d_frame_cycles", v), cyc - t0, vecs[v].dur_nocs);
            nb = vecs[v].n + 2;
`endif
            frames_exp++;
            check($sformatf("v%0d_frame_cnt", v), frame_cnt, frames_exp);
            check($sformatf("v%0d_rx_nbytes", v), rx_q.size(), nb);
            for (int k = 0; k < nb; k++) begin
                if (k < rx_q.size())
                    check($sformatf("v%0d_rx_byte%0d", v, k), rx_q[k], vecs[v].line[k]);
            end
            $display("vector %0d: %0d payload bytes, latency %0d, duration %0d, %0d line bytes",
                     v, vecs[v].n, t0 - last_wr, cyc - t0, rx_q.size());
            repeat (5) @(negedge clk);
        end

        // Fill: 12 back-to-back writes into an 8-deep buffer
        rx_q.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) first_wr = cyc + 1;
            if (i == 7) check("fill_not_full_after_7", bus.IN_FULL, 0);
            if (i == 8) check("fill_full_after_8", bus.IN_FULL, 1);
            bus.IN_WR   = 1'b1;
            bus.IN_DATA = 8'(i + 1);
        end
        @(negedge clk);
        bus.IN_WR = 1'b0;
        check("fill_drop_cnt", drop_cnt, 4);
        // Frame starts one edge after the 4th write; the first payload pop
        // is the first cycle of the third byte slot.
        pop_neg = first_wr + 4 + 80;
        while (cyc < pop_neg) @(negedge clk);
        check("fill_full_in_pop_cycle", bus.IN_FULL, 1);
        @(negedge clk);
        check("fill_full_after_pop", bus.IN_FULL, 0);
        got = 0;
        for (int k = 0; k < 1500 && !got; k++) begin
            @(negedge clk);
            if (frame_cnt == 16'(frames_exp + 2) && !busy) got = 1;
        end
        check("fill_two_frames_done", int'(got), 1);
        frames_exp += 2;
        check("fill_rx_nbytes", rx_q.size(), exp_fill.size());
        for (int k = 0; k < exp_fill.size(); k++) begin
            if (k < rx_q.size()) check($sformatf("fill_rx_byte%0d", k), rx_q[k], exp_fill[k]);
        end
        repeat (150) @(negedge clk);
        check("fill_no_extra_frame", busy, 0);
        $display("fill: 12 writes, drop_cnt %0d, %0d line bytes, frame_cnt %0d",
                 drop_cnt, rx_q.size(), frame_cnt);

        // Reset in the middle of the LEN byte
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.IN_WR   = 1'b1;
            bus.IN_DATA = 8'h11 * 8'(i + 1);
        end
        @(negedge clk);
        bus.IN_WR = 1'b0;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) got = 1;
        end
        check("rstmid_start_seen", int'(got), 1);
        t0 = cyc;
        while (cyc < t0 + 41) @(negedge clk);
        check("rstmid_len_start_bit", uart_tx, 0);
        rst_n = 1'b0;
        #1;
        check("rstmid_uart_tx", uart_tx, 1);
        check("rstmid_busy", busy, 0);
        check("rstmid_frame_cnt", frame_cnt, 0);
        check("rstmid_in_full", bus.IN_FULL, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (uart_tx == 1'b0 || busy) lows++;
        end
        check("rstmid_line_idle_after", lows, 0);
        check("rstmid_frame_cnt_after", frame_cnt, 0);
        $display("reset mid-frame: line idle samples ok=%0d, frame_cnt %0d", lows == 0, frame_cnt);
        rx_q.delete();

        // IN_WR held 20 cycles with incrementing data while frames go out
        n_drop_model = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.IN_FULL) n_drop_model++;
            bus.IN_WR   = 1'b1;
            bus.IN_DATA = 8'(8'h30 + i);
        end
        @(negedge clk);
        bus.IN_WR = 1'b0;
        check("hold_writes_seen_full", n_drop_model, 12);
        check("hold_drop_cnt", drop_cnt, n_drop_model);
        got = 0;
        for (int k = 0; k < 1500 && !got; k++) begin
            @(negedge clk);
            if (frame_cnt == 16'd2 && !busy) got = 1;
        end
        check("hold_two_frames_done", int'(got), 1);
        pay_q.delete();
        idx = 0;
        while (idx + 1 < rx_q.size()) begin
            check($sformatf("hold_sync_at%0d", idx), rx_q[idx], 8'hA5);
            plen = int'(rx_q[idx + 1]);
            for (int k = 0; k < plen; k++) begin
                if (idx + 2 + k < rx_q.size()) pay_q.push_back(rx_q[idx + 2 + k]);
            end
`ifdef DATA_UART_TX_CHECKSUM_EN
            idx = idx + plen + 3;
`else
            idx = idx + plen + 2;
`endif
        end
        check("hold_payload_len", pay_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < pay_q.size()) check($sformatf("hold_payload%0d", k), pay_q[k], 8'h30 + k);
        end
        $display("hold: 20 writes, %0d refused, drop_cnt %0d, %0d payload bytes received",
                 n_drop_model, drop_cnt, pay_q.size());

        check("framing_errors", framing_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_uart_tx.md
# data_uart_tx

Byte-stream sink that drains the 8-bit output of the readout data FIFO and ships it over a UART TX line as framed packets. Buffers incoming bytes, groups them into frames of SYNC, LEN, payload and optional checksum, and serialises 8N1 at a fixed bit divider. Sits directly downstream of the 32-to-8 data FIFO and replaces a network TX path on boards without Ethernet.

## Interface
- CLK_DIV, 434: clock cycles per UART bit (50 MHz / 115200); legal range 4..65535.
- DEPTH, 64: internal byte buffer depth; power of two, 4..4096.
- MAX_LEN, 16: maximum payload bytes per frame, 1..255.
- FLUSH_CYCLES, 50000: idle cycles before a short frame is flushed, 1..2^24-1.

Ports:
- CLK  in  1  single clock, the bus clock; all logic runs on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_WR  in  1  write strobe; a byte is accepted on a rising edge with IN_WR=1 and IN_FULL=0.
- IN_DATA  in  8  byte written with IN_WR.
- IN_FULL  out  1  buffer holds DEPTH bytes. Decoded from registers only, never from IN_WR.
- UART_TX  out  1  serial line, idle high; registered.
- BUSY  out  1  frame in progress (state != IDLE).
- FRAME_CNT  out  16  completed frames, wraps at 0xFFFF→0.
- DROP_CNT  out  8  writes attempted while IN_FULL=1; saturates at 0xFF.

## Operation
- Buffer: circular, DEPTH entries, count register 0..DEPTH. Push and pop in the same cycle leave count unchanged. Writes are accepted in every FSM state.
- Flush timer: 24 bits. Cleared on every accepted write and on frame start. Increments in IDLE while count>0. Saturates at FLUSH_CYCLES.
- FSM states: IDLE, SYNC, LEN, DATA, CSUM.
- IDLE→SYNC when count>=MAX_LEN, or when count>0 and timer==FLUSH_CYCLES.
  - On that edge, latch len=min(count,MAX_LEN) and clear the checksum accumulator.
  - count is sampled before the current cycle's push.
- SYNC sends 0xA5, then → LEN.
- LEN sends len, then → DATA. len is added to the checksum.
- DATA pops one byte at the start of each byte slot, sends it and adds it to the checksum. After len bytes → CSUM.
- CSUM sends the 8-bit sum of len and all payload bytes, mod 256, then → IDLE. On that transition FRAME_CNT increments.
- The serialiser is a 10-bit shift: start bit 0, data LSB first, stop bit 1. A new start condition is evaluated on the cycle after return to IDLE.

## Timing
- Reset values: UART_TX=1, IN_FULL=0, BUSY=0, FRAME_CNT=0, DROP_CNT=0, buffer empty, timer 0, state IDLE.
- IN_FULL updates the cycle after the count change.
- Frame start: UART_TX drives the SYNC start bit in the cycle after the IDLE→SYNC condition is sampled. BUSY rises in the same cycle.
- Each bit is held exactly CLK_DIV cycles. Consecutive bytes are back-to-back, so the next start bit directly follows the previous stop bit.
- Frame duration is (len+3)·10·CLK_DIV cycles, or (len+2)·10·CLK_DIV with checksum compiled out. BUSY falls at the end of the last stop bit.
- A payload pop occurs on the first cycle of the byte slot. A write in that cycle when count==DEPTH is refused (IN_FULL=1) and counted in DROP_CNT.
- Reset asserted mid-frame: UART_TX returns to 1 immediately (asynchronously). All buffered data is discarded. No partial-frame recovery.

## Configuration
- DATA_UART_TX_CHECKSUM_EN defined: CSUM state present, frame ends with the checksum byte.
- Undefined: DATA→IDLE directly after the last payload byte, and the checksum accumulator is removed. The LEN byte and the remaining format are unchanged.

## Test plan
All scenarios use CLK_DIV=4, MAX_LEN=4, DEPTH=8, FLUSH_CYCLES=100, checksum enabled unless stated.
- Write 0x01,0x02,0x03,0x04 on consecutive cycles → line carries A5 04 01 02 03 04 0E. Frame lasts 280 cycles, then FRAME_CNT=1 and BUSY=0.
- Write single 0x55 → SYNC start bit begins 101 cycles after the write. Bytes A5 01 55 56 follow.
- Write 12 bytes back-to-back with no reads → IN_FULL=1 after byte 8. DROP_CNT=4. Two 4-byte frames follow, and IN_FULL drops once the first payload pop occurs.
- Assert RST_N=0 during the LEN byte → UART_TX=1 in the same cycle, BUSY=0, FRAME_CNT unchanged at reset value. After release the line stays idle with no writes.
- Build without DATA_UART_TX_CHECKSUM_EN and write 0x10,0x20,0x30,0x40 → A5 04 10 20 30 40, 240 cycles.
- Hold IN_WR for 20 cycles with DATA incrementing while frames are sent → received payload matches the written sequence minus the dropped writes, in order. DROP_CNT equals the count of writes made with IN_FULL=1.
